// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that lets two requesters share one 8-bit ALU.
// It drives the ALU operands from registers, waits SETTLE_CYCLES, then returns RESULT/ZERO with a one-cycle ACK.
module alu_share_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic [2:0] OP0,
    input  logic [7:0] A0,
    input  logic [7:0] B0,
    input  logic       REQ1,
    input  logic [2:0] OP1,
    input  logic [7:0] A1,
    input  logic [7:0] B1,
    output logic       ACK0,
    output logic       ACK1,
    output logic       ERR0,
    output logic       ERR1,
    output logic [7:0] RESULT_OUT,
    output logic       ZERO_OUT,
    output logic       BUSY,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT,
    input  logic       ALU_ZERO,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       err0_q, err0_d;
    logic       err1_q, err1_d;
    logic       busy_q, busy_d;
    logic       zero_q, zero_d;
    logic [7:0] result_q, result_d;
    logic [7:0] data1_q, data1_d;
    logic [7:0] data2_q, data2_d;
    logic [2:0] sel_q, sel_d;

    logic       gnt;
    logic [2:0] gnt_op;
    logic [7:0] gnt_a;
    logic [7:0] gnt_b;

    // Under contention the port that did not win last time gets the grant.
    always_comb begin
        gnt    = (REQ0 && REQ1) ? ~last_q : REQ1;
        gnt_op = gnt ? OP1 : OP0;
        gnt_a  = gnt ? A1 : A0;
        gnt_b  = gnt ? B1 : B0;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        owner_d  = owner_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        zero_d   = zero_q;
        result_d = result_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        sel_d    = sel_q;

        case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    owner_d = gnt;
                    if (REQ0 && REQ1) begin
                        last_d = gnt;
                    end
                    if (gnt_op[2]) begin
                        // Reserved select: answer immediately, leave the ALU untouched.
                        result_d = 8'h00;
                        zero_d   = 1'b0;
                        ack0_d   = ~gnt;
                        ack1_d   = gnt;
                        err0_d   = ~gnt;
                        err1_d   = gnt;
                        state_d  = RESP;
                    end else begin
                        data1_d = gnt_a;
                        data2_d = gnt_b;
                        sel_d   = gnt_op;
                        cnt_d   = SETTLE;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d = ALU_RESULT;
                    zero_d   = ALU_ZERO;
                    ack0_d   = ~owner_q;
                    ack1_d   = owner_q;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= 8'h00;
            data1_q  <= 8'h00;
            data2_q  <= 8'h00;
            sel_q    <= 3'b000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            busy_q   <= busy_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            sel_q    <= sel_d;
        end
    end

    assign ACK0       = ack0_q;
    assign ACK1       = ack1_q;
    assign ERR0       = err0_q;
    assign ERR1       = err1_q;
    assign BUSY       = busy_q;
    assign ZERO_OUT   = zero_q;
    assign RESULT_OUT = result_q;
    assign ALU_DATA1  = data1_q;
    assign ALU_DATA2  = data2_q;
    assign ALU_SELECT = sel_q;
    assign state_dbg  = state_q;

endmodule
